// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM bank with shared prescaler/period counter
// Duty and period are double-buffered and swap in on wrap; prescale and mask apply immediately.
module pwm_bank #(
  parameter  int CHANNELS    = 8,
  parameter  int CNT_WIDTH   = 8,
  parameter  int PRESC_WIDTH = 8,
  localparam int ADDR_W      = $clog2(CHANNELS + 3)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CNT_WIDTH-1:0] wr_data,
  output logic [CHANNELS-1:0]  pwm_out,
  output logic                 period_tick
);

  logic [PRESC_WIDTH-1:0] pre_cnt_q, pre_cnt_d, presc_q, presc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, top_sh_q, top_sh_d, top_act_q, top_act_d;
  logic [CNT_WIDTH-1:0]   duty_sh_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]   duty_sh_d  [CHANNELS];
  logic [CNT_WIDTH-1:0]   duty_act_q [CHANNELS];
  logic [CNT_WIDTH-1:0]   duty_act_d [CHANNELS];
  logic [CHANNELS-1:0]    mask_q, mask_d, pwm_q, pwm_d;
  logic                   tick_q, tick_d;
  logic                   step, wrap;

  always_comb begin
    step      = ena && (pre_cnt_q >= presc_q);
    wrap      = step && (cnt_q >= top_act_q);
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    top_sh_d  = top_sh_q;
    top_act_d = wrap ? top_sh_q : top_act_q;
    presc_d   = presc_q;
    mask_d    = mask_q;
    pwm_d     = '0;
    tick_d    = wrap;

    if (ena) pre_cnt_d = step ? '0 : pre_cnt_q + 1'b1;
    if (wrap)      cnt_d = '0;
    else if (step) cnt_d = cnt_q + 1'b1;

    // Active duty is loaded from the pre-write shadow, so a write on the wrap cycle waits a period.
    for (int i = 0; i < CHANNELS; i++) begin
      duty_sh_d[i]  = duty_sh_q[i];
      duty_act_d[i] = wrap ? duty_sh_q[i] : duty_act_q[i];
      pwm_d[i]      = ena && mask_q[i] && (cnt_q < duty_act_q[i]);
    end

    if (wr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_addr == ADDR_W'(i)) duty_sh_d[i] = wr_data;
      end
      if (wr_addr == ADDR_W'(CHANNELS))     top_sh_d = wr_data;
      if (wr_addr == ADDR_W'(CHANNELS + 1)) presc_d  = wr_data[PRESC_WIDTH-1:0];
      if (wr_addr == ADDR_W'(CHANNELS + 2)) mask_d   = wr_data[CHANNELS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      top_sh_q  <= '1;
      top_act_q <= '1;
      presc_q   <= '0;
      mask_q    <= '0;
      pwm_q     <= '0;
      tick_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      top_sh_q  <= top_sh_d;
      top_act_q <= top_act_d;
      presc_q   <= presc_d;
      mask_q    <= mask_d;
      pwm_q     <= pwm_d;
      tick_q    <= tick_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed period/duty measurements plus random traffic against a reference model
module tb_pwm_bank;
  localparam int CH = 8;
  localparam int CW = 8;
  localparam int PW = 8;
  localparam int AW = $clog2(CH + 3);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  pwm_bank #(.CHANNELS(CH), .CNT_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: registers held as plain integers, one update per clock.
  int            m_pre, m_cnt, m_top_sh, m_top_act, m_presc;
  int            m_duty_sh [CH];
  int            m_duty_act[CH];
  logic [CH-1:0] m_mask, m_pwm;
  logic          m_tick;

  // Window statistics measured from the DUT between consecutive period ticks.
  int acc_len, last_len, n_ticks;
  int acc_hi[CH];
  int last_hi[CH];

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_presc = 0; m_top_sh = 255; m_top_act = 255;
    m_mask = '0; m_pwm = '0; m_tick = 1'b0;
    for (int i = 0; i < CH; i++) begin m_duty_sh[i] = 0; m_duty_act[i] = 0; end
    acc_len = 0;
    for (int i = 0; i < CH; i++) acc_hi[i] = 0;
  endtask

  task automatic model_clock();
    bit step, wrap;
    int a, d;
    a = int'(wr_addr);
    d = int'(wr_data);
    step = ena && (m_pre >= m_presc);
    if (ena) m_pre = step ? 0 : m_pre + 1;
    wrap = step && (m_cnt >= m_top_act);
    for (int i = 0; i < CH; i++) m_pwm[i] = ena && m_mask[i] && (m_cnt < m_duty_act[i]);
    m_tick = wrap;
    if (wrap) begin
      m_cnt = 0;
      m_top_act = m_top_sh;
      for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_sh[i];
    end else if (step) begin
      m_cnt = m_cnt + 1;
    end
    if (wr_en) begin
      if (a < CH)           m_duty_sh[a] = d;
      else if (a == CH)     m_top_sh = d;
      else if (a == CH + 1) m_presc = d % (1 << PW);
      else if (a == CH + 2) m_mask = CH'(d);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    if (rst_n) model_clock();
    #1;
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("period_tick", 32'(period_tick), 32'(m_tick));
    acc_len++;
    for (int i = 0; i < CH; i++) acc_hi[i] += int'(pwm_out[i]);
    if (period_tick) begin
      last_len = acc_len;
      acc_len  = 0;
      for (int i = 0; i < CH; i++) begin last_hi[i] = acc_hi[i]; acc_hi[i] = 0; end
      n_ticks++;
    end
  endtask

  task automatic wr(input int addr, input int data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = CW'(data);
    step_clk();
    wr_en = 1'b0;
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int target, c;
    target = n_ticks + n;
    c = 0;
    while (n_ticks < target && c < budget) begin step_clk(); c++; end
    if (n_ticks < target) check("tick_timeout", 32'(n_ticks), 32'(target));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_pwm", 32'(pwm_out), 0);
    check("rst_async_tick", 32'(period_tick), 0);
    step_clk();
    rst_n = 1'b1;
  endtask

  initial begin
    int r, a, d;
    n_ticks = 0; last_len = 0;
    for (int i = 0; i < CH; i++) last_hi[i] = 0;
    model_reset();
    repeat (3) step_clk();
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_tick", 32'(period_tick), 0);
    rst_n = 1'b1;
    ena = 1'b1;

    // TOP=9, PRESC=0, duty0=3
    wr(CH, 9); wr(CH + 1, 0); wr(0, 3); wr(CH + 2, 8'h01);
    wait_ticks(2, 2000);
    check("basic_len", 32'(last_len), 10);
    check("basic_hi0", 32'(last_hi[0]), 3);
    wait_ticks(1, 50);
    check("basic_len2", 32'(last_len), 10);
    check("basic_hi0_2", 32'(last_hi[0]), 3);

    // PRESC=3, duty1=5
    wr(CH + 1, 3); wr(1, 5); wr(CH + 2, 8'h02);
    wait_ticks(2, 500);
    check("presc_len", 32'(last_len), 40);
    check("presc_hi1", 32'(last_hi[1]), 20);
    check("presc_hi0_masked", 32'(last_hi[0]), 0);

    // Duty change mid-period and on the wrap cycle
    wr(CH + 1, 0); wr(2, 3); wr(CH + 2, 8'h04);
    wait_ticks(2, 200);
    check("dbuf_len", 32'(last_len), 10);
    check("dbuf_hi2", 32'(last_hi[2]), 3);
    repeat (3) step_clk();
    wr(2, 7);
    wait_ticks(1, 50);
    check("dbuf_mid_cur", 32'(last_hi[2]), 3);
    wait_ticks(1, 50);
    check("dbuf_mid_next", 32'(last_hi[2]), 7);
    r = n_ticks;
    repeat (9) step_clk();
    wr(2, 2);
    check("dbuf_coinc_align", 32'(n_ticks - r), 1);
    check("dbuf_coinc_cur", 32'(last_hi[2]), 7);
    wait_ticks(1, 50);
    check("dbuf_coinc_next", 32'(last_hi[2]), 7);
    wait_ticks(1, 50);
    check("dbuf_coinc_later", 32'(last_hi[2]), 2);

    // Duty extremes with TOP=99 and a masked channel
    wr(CH, 99); wr(0, 0); wr(1, 200); wr(2, 50); wr(CH + 2, 8'h03);
    wait_ticks(2, 500);
    check("ext_len", 32'(last_len), 100);
    check("ext_duty0", 32'(last_hi[0]), 0);
    check("ext_duty200", 32'(last_hi[1]), 100);
    check("ext_masked", 32'(last_hi[2]), 0);

    // ena low for 15 clocks mid-period
    repeat (30) step_clk();
    ena = 1'b0;
    repeat (15) begin
      step_clk();
      check("ena_off_pwm", 32'(pwm_out), 0);
      check("ena_off_tick", 32'(period_tick), 0);
    end
    ena = 1'b1;
    wait_ticks(1, 300);
    check("ena_len", 32'(last_len), 115);
    check("ena_hi1", 32'(last_hi[1]), 100);

    // Out-of-map writes are ignored
    wr(11, 8'hFF); wr(15, 8'h00); wr(13, 8'h05);
    wait_ticks(2, 500);
    check("badaddr_len", 32'(last_len), 100);
    check("badaddr_hi1", 32'(last_hi[1]), 100);
    check("badaddr_hi0", 32'(last_hi[0]), 0);
    check("badaddr_hi3", 32'(last_hi[3]), 0);

    // Reset mid-period restores TOP=255
    repeat (37) step_clk();
    pulse_reset();
    step_clk();
    wr(0, 128); wr(CH + 2, 8'h01);
    wait_ticks(2, 1000);
    check("rst_top_len", 32'(last_len), 256);
    check("rst_top_hi0", 32'(last_hi[0]), 128);

    // Random traffic, cycle-by-cycle against the model
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 999);
      if (r < 2) begin
        pulse_reset();
      end else if (r < 50) begin
        ena = ~ena;
        step_clk();
      end else if (r < 200) begin
        a = $urandom_range(0, 15);
        if (a == CH)          d = $urandom_range(0, 15);
        else if (a == CH + 1) d = $urandom_range(0, 3);
        else if (a < CH)      d = $urandom_range(0, 20);
        else                  d = $urandom_range(0, 255);
        wr(a, d);
      end else begin
        step_clk();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, meaning number of PWM outputs; legal range 1..CNT_WIDTH.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning width of period counter, duty and period registers, and the write data bus.
REQ-003 SHALL have parameter PRESC_WIDTH, default 8, meaning prescaler width; PRESC_WIDTH <= CNT_WIDTH.
REQ-004 SHALL derive local ADDR_W = clog2(CHANNELS+3).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ena  input  1  run enable; low freezes counting and forces outputs low.
REQ-008 wr_en  input  1  one-cycle register write strobe.
REQ-009 wr_addr  input  ADDR_W  register address.
REQ-010 wr_data  input  CNT_WIDTH  register write data.
REQ-011 pwm_out  output  CHANNELS  registered PWM outputs.
REQ-012 period_tick  output  1  registered one-cycle pulse at each period wrap.

Function
REQ-013 Register map SHALL be: addr 0..CHANNELS-1 duty shadow[i]; addr CHANNELS period shadow (TOP); addr CHANNELS+1 prescale (PRESC, low PRESC_WIDTH bits); addr CHANNELS+2 channel enable mask (low CHANNELS bits).
REQ-014 Writes to addresses >= CHANNELS+3 SHALL be ignored with no state change.
REQ-015 Writes SHALL be accepted regardless of ena.
REQ-016 Prescaler counter SHALL increment each cycle while ena=1; when pre_cnt >= PRESC it SHALL clear to 0 and assert internal step for that cycle (PRESC=0 gives a step every cycle).
REQ-017 Period counter cnt SHALL increment on each step; on step with cnt >= TOP_active it SHALL wrap to 0 (wrap event).
REQ-018 On a wrap event, all duty shadows and the TOP shadow SHALL be copied to their active registers; values written in the same cycle as the wrap SHALL land only in the shadow and take effect at the following wrap.
REQ-019 PRESC and the enable mask SHALL take effect on the cycle after the write (not double-buffered).
REQ-020 pwm_out[i] SHALL be registered as ena & en_mask[i] & (cnt < duty_active[i]), one clock of latency from cnt.
REQ-021 Duty 0 SHALL give a constant low; duty > TOP_active SHALL give a constant high; period length SHALL be (TOP_active+1)*(PRESC+1) clocks.
REQ-022 period_tick SHALL be high for exactly the one cycle following each wrap event.
REQ-023 ena=0 SHALL hold pre_cnt and cnt, force pwm_out and period_tick to 0 on the next edge; ena return SHALL resume counting from the held values.
REQ-024 All comparisons SHALL be unsigned; no arithmetic overflow beyond CNT_WIDTH bits.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear pwm_out, period_tick, pre_cnt, cnt, all duty shadow/active registers, PRESC and the enable mask to 0.
REQ-026 Reset SHALL set TOP shadow and TOP active to all-ones (2^CNT_WIDTH-1).
REQ-027 Reset asserted mid-period SHALL abort the period; after release the first step SHALL occur per REQ-016 from pre_cnt=0, cnt=0.

Verification
REQ-028 Defaults, ena=1, TOP=9, PRESC=0, duty0=3, mask=0x01, wait two wraps -> pwm_out[0] high 3 of every 10 clocks, period_tick every 10 clocks.
REQ-029 TOP=9, PRESC=3, duty1=5, mask=0x02 -> 40-clock period, pwm_out[1] high 20 clocks per period.
REQ-030 duty2 changed 3->7 mid-period -> current period still 3 high, next full period 7 high; write coincident with wrap -> applied one period later.
REQ-031 duty=0 and duty=200 with TOP=99 -> constant low and constant high respectively; mask bit clear -> constant low regardless of duty.
REQ-032 ena dropped for 15 clocks mid-period -> outputs and period_tick 0, cnt frozen, resumes with same count; write to address 11 -> no register changes.
REQ-033 rst_n pulsed low mid-period -> all outputs 0 immediately, TOP reads back as 255 via period length 256 clocks after setting duty0=128, mask=0x01.
